// File: rtl/lane_pkg.sv
// Shared types and default sizes for the byte-lane serializer.
package lane_pkg;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 3;
  localparam int IDX_W     = $clog2(NUM_LANES);

  typedef logic [LANE_W-1:0]      lane_t;
  typedef lane_t [NUM_LANES-1:0]  lane_vec_t;
  typedef logic [IDX_W-1:0]       lane_idx_t;

  typedef enum logic {IDLE, SEND} ser_state_e;
endpackage

// File: rtl/lane_next_sel.sv
// Finds the lowest set keep bit at or above a start index, and whether it is
// the highest set bit of the mask.
module lane_next_sel #(
  parameter int NUM_LANES = 3,
  localparam int IDX_W = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] keep,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     idx,
  output logic                 found,
  output logic                 is_last
);
  int   sel;
  logic more;

  always_comb begin
    sel   = 0;
    found = 1'b0;
    more  = 1'b0;
    // Scan downward so the lowest qualifying lane wins.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (keep[i] && (i >= int'(start))) begin
        sel   = i;
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (keep[i] && (i > sel)) more = 1'b1;
    end
    idx     = IDX_W'(sel);
    is_last = found && !more;
  end
endmodule

// File: rtl/byte_lane_serializer.sv
// Serializes the kept lanes of a multi-lane word onto a byte stream, lane 0
// first, with valid/ready on both sides and no bubble between words.
module byte_lane_serializer #(
  parameter int NUM_LANES = lane_pkg::NUM_LANES,
  parameter int LANE_W    = lane_pkg::LANE_W,
  localparam int IDX_W    = $clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*LANE_W-1:0] in_data,
  input  logic [NUM_LANES-1:0]        in_keep,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_lane,
  output logic                        out_last,
  output logic                        busy
);
  import lane_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, data is stable while valid & !ready.

  ser_state_e                  state, state_n;
  logic [NUM_LANES*LANE_W-1:0] data_q;
  logic [NUM_LANES-1:0]        keep_q;

  logic             in_hs, out_hs;
  logic             load_first, advance, go_idle;
  logic [IDX_W-1:0] first_idx, adv_idx, adv_start;
  logic             first_found, first_last, adv_found, adv_last;
  logic [LANE_W-1:0] first_byte, adv_byte;

  assign adv_start = out_lane + IDX_W'(1);

  lane_next_sel #(.NUM_LANES(NUM_LANES)) u_first_sel (
    .keep    (in_keep),
    .start   ('0),
    .idx     (first_idx),
    .found   (first_found),
    .is_last (first_last)
  );

  lane_next_sel #(.NUM_LANES(NUM_LANES)) u_adv_sel (
    .keep    (keep_q),
    .start   (adv_start),
    .idx     (adv_idx),
    .found   (adv_found),
    .is_last (adv_last)
  );

  always_comb begin
    first_byte = '0;
    adv_byte   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (IDX_W'(i) == first_idx) first_byte = in_data[i*LANE_W +: LANE_W];
      if (IDX_W'(i) == adv_idx)   adv_byte   = data_q[i*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    state_n    = state;
    load_first = 1'b0;
    advance    = 1'b0;
    go_idle    = 1'b0;
    out_valid  = (state == SEND);
    busy       = (state == SEND);
    // In SEND a new word may only enter on the cycle the last byte leaves.
    in_ready   = (state == IDLE) || (out_last && out_ready);
    in_hs      = in_valid && in_ready;
    out_hs     = out_valid && out_ready;
    case (state)
      IDLE: begin
        if (in_hs && first_found) begin
          load_first = 1'b1;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (!out_last && adv_found) begin
            advance = 1'b1;
          end else if (in_hs && first_found) begin
            load_first = 1'b1;
          end else begin
            go_idle = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      keep_q   <= '0;
      out_data <= '0;
      out_lane <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      if (load_first) begin
        data_q   <= in_data;
        keep_q   <= in_keep;
        out_data <= first_byte;
        out_lane <= first_idx;
        out_last <= first_last;
      end else if (advance) begin
        out_data <= adv_byte;
        out_lane <= adv_idx;
        out_last <= adv_last;
      end else if (go_idle) begin
        keep_q   <= '0;
        out_data <= '0;
        out_lane <= '0;
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_byte_lane_serializer.sv
// Directed bench for byte_lane_serializer: cycle-exact checks plus an output
// scoreboard of {lane, last, data} entries.
module tb_byte_lane_serializer;
  localparam int NL = 3;
  localparam int LW = 8;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NL*LW-1:0] in_data;
  logic [NL-1:0] in_keep;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          out_last;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  byte_lane_serializer #(.NUM_LANES(NL), .LANE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted output byte must match the head of exp_q.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", {21'd0, out_lane, out_last, out_data}, 32'h0);
      end else begin
        check("sb_byte", {16'd0, 5'd0, out_lane, out_last, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [W-1:0] ent(input logic [1:0] lane, input logic last, input logic [7:0] d);
    return {5'd0, lane, last, d};
  endfunction

  // Driver tasks
  task automatic send_word(input logic [NL*LW-1:0] d, input logic [NL-1:0] k);
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    budget   = 50;
    #1;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (budget == 0) check("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 24'hEEEEEE;
    in_keep  = 3'b111;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 50;
    while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] lane, input logic last);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
    check({tag, "_lane"},  {30'd0, out_lane},  {30'd0, lane});
    check({tag, "_last"},  {31'd0, out_last},  {31'd0, last});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_out("rst", 1'b0, 8'h00, 2'd0, 1'b0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Full word: 3 consecutive bytes starting the cycle after accept.
    exp_q.push_back(ent(2'd0, 1'b0, 8'h11));
    exp_q.push_back(ent(2'd1, 1'b0, 8'h22));
    exp_q.push_back(ent(2'd2, 1'b1, 8'h33));
    send_word(24'h332211, 3'b111);
    check_out("full0", 1'b1, 8'h11, 2'd0, 1'b0);
    check("full0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_out("full1", 1'b1, 8'h22, 2'd1, 1'b0);
    @(negedge clk);
    check_out("full2", 1'b1, 8'h33, 2'd2, 1'b1);
    @(negedge clk);
    check("full_done", {31'd0, out_valid}, 32'd0);
    check("full_done_busy", {31'd0, busy}, 32'd0);
    wait_idle();

    // Sparse keep: lane 1 skipped at no cost.
    exp_q.push_back(ent(2'd0, 1'b0, 8'hA0));
    exp_q.push_back(ent(2'd2, 1'b1, 8'hC2));
    send_word(24'hC2B1A0, 3'b101);
    check_out("sparse0", 1'b1, 8'hA0, 2'd0, 1'b0);
    @(negedge clk);
    check_out("sparse1", 1'b1, 8'hC2, 2'd2, 1'b1);
    @(negedge clk);
    check("sparse_done", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // Backpressure on the second byte.
    exp_q.push_back(ent(2'd0, 1'b0, 8'h11));
    exp_q.push_back(ent(2'd1, 1'b0, 8'h22));
    exp_q.push_back(ent(2'd2, 1'b1, 8'h33));
    send_word(24'h332211, 3'b111);
    check_out("bp0", 1'b1, 8'h11, 2'd0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_out("bp_hold", 1'b1, 8'h22, 2'd1, 1'b0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_out("bp_rel", 1'b1, 8'h22, 2'd1, 1'b0);
    @(negedge clk);
    check_out("bp2", 1'b1, 8'h33, 2'd2, 1'b1);
    wait_idle();

    // Back-to-back words: accepted on the last-byte cycle, no gap.
    exp_q.push_back(ent(2'd0, 1'b0, 8'h01));
    exp_q.push_back(ent(2'd1, 1'b1, 8'h02));
    exp_q.push_back(ent(2'd1, 1'b0, 8'h05));
    exp_q.push_back(ent(2'd2, 1'b1, 8'h06));
    in_valid = 1'b1; in_data = 24'h030201; in_keep = 3'b011;
    #1;
    check("b2b_rdy_a", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_data = 24'h060504; in_keep = 3'b110;
    #1;
    check_out("b2b0", 1'b1, 8'h01, 2'd0, 1'b0);
    check("b2b_rdy_mid", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    check_out("b2b1", 1'b1, 8'h02, 2'd1, 1'b1);
    check("b2b_rdy_last", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_out("b2b2", 1'b1, 8'h05, 2'd1, 1'b0);
    @(negedge clk);
    check_out("b2b3", 1'b1, 8'h06, 2'd2, 1'b1);
    @(negedge clk);
    check("b2b_done", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // Empty keep between two full words is dropped.
    exp_q.push_back(ent(2'd0, 1'b0, 8'h11));
    exp_q.push_back(ent(2'd1, 1'b0, 8'h12));
    exp_q.push_back(ent(2'd2, 1'b1, 8'h13));
    send_word(24'h131211, 3'b111);
    send_word(24'h999999, 3'b000);
    check("empty_valid", {31'd0, out_valid}, 32'd0);
    check("empty_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(ent(2'd0, 1'b0, 8'h21));
    exp_q.push_back(ent(2'd1, 1'b0, 8'h22));
    exp_q.push_back(ent(2'd2, 1'b1, 8'h23));
    send_word(24'h232221, 3'b111);
    check_out("empty_next", 1'b1, 8'h21, 2'd0, 1'b0);
    wait_idle();

    // Reset while the second of three bytes is pending.
    exp_q.push_back(ent(2'd0, 1'b0, 8'h9A));
    send_word(24'h9C9B9A, 3'b111);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_out("mid_pend", 1'b1, 8'h9B, 2'd1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("mid_rst", 1'b0, 8'h00, 2'd0, 1'b0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    exp_q.push_back(ent(2'd0, 1'b0, 8'hD0));
    exp_q.push_back(ent(2'd1, 1'b0, 8'hD1));
    exp_q.push_back(ent(2'd2, 1'b1, 8'hD2));
    send_word(24'hD2D1D0, 3'b111);
    check_out("post_rst", 1'b1, 8'hD0, 2'd0, 1'b0);
    wait_idle();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
